// File: rtl/hc194_pkg.sv
`default_nettype none
// ============================================================================
// Module  : hc194_pkg
// Brief   : Shared states, pattern/mode codes and serial-bit helper for the
//           74HC194 pattern sequencer.
// Revision: 1.0
// ============================================================================
package hc194_pkg;

   typedef enum logic [2:0] {
      IDLE    = 3'd0,
      LOAD    = 3'd1,
      RUN_L   = 3'd2,
      RUN_R   = 3'd3,
      HOLD_ST = 3'd4
   } state_t;

   localparam logic [1:0] PAT_RING    = 2'b00;
   localparam logic [1:0] PAT_JOHNSON = 2'b01;
   localparam logic [1:0] PAT_BOUNCE  = 2'b10;
   localparam logic [1:0] PAT_HOLD    = 2'b11;

   localparam logic [1:0] MODE_HOLD = 2'b00;
   localparam logic [1:0] MODE_SHL  = 2'b01;
   localparam logic [1:0] MODE_SHR  = 2'b10;
   localparam logic [1:0] MODE_LOAD = 2'b11;

   localparam int BOUNCE_STEPS = 3;

   // Bit shifted into Q[0] on a toward-Q[3] shift, from the current register value.
   function automatic logic shl_serial(input logic [1:0] pat, input logic [3:0] q);
      logic bit_o;
      case (pat)
         PAT_RING:    bit_o = q[3];
         PAT_JOHNSON: bit_o = ~q[3];
         default:     bit_o = 1'b0;
      endcase
      return bit_o;
   endfunction

endpackage
`default_nettype wire

// File: rtl/hc194_tick_div.sv
`default_nettype none
// ============================================================================
// Module  : hc194_tick_div
// Brief   : Step prescaler; one-cycle tick when the count reaches max(div,1).
// Revision: 1.0
// ============================================================================
module hc194_tick_div #(
   parameter int DIV_W = 8
) (
   input  logic             clk_i,
   input  logic             rst_i,
   input  logic             clr_i,
   input  logic             en_i,
   input  logic [DIV_W-1:0] div_i,
   output logic             tick_o
);

   logic [DIV_W-1:0] cnt_q;
   logic [DIV_W-1:0] cnt_d;
   logic [DIV_W-1:0] max_cnt;

   // A shrunk div below the current count is passed by and caught after wrap.
   always_comb begin
      max_cnt = (div_i == '0) ? DIV_W'(1) : div_i;
      tick_o  = en_i && (cnt_q == max_cnt);
      cnt_d   = cnt_q;
      if (clr_i) begin
         cnt_d = '0;
      end else if (en_i) begin
         cnt_d = tick_o ? '0 : cnt_q + DIV_W'(1);
      end
   end

   always_ff @(posedge clk_i or posedge rst_i) begin
      if (rst_i) begin
         cnt_q <= '0;
      end else begin
         cnt_q <= cnt_d;
      end
   end

endmodule
`default_nettype wire

// File: rtl/hc194_seq_ctrl.sv
`default_nettype none
// ============================================================================
// Module  : hc194_seq_ctrl
// Brief   : Seeds a 74HC194 and issues paced ring/Johnson/bounce shift commands.
// Revision: 1.0
// ============================================================================
module hc194_seq_ctrl
   import hc194_pkg::*;
#(
   parameter int DIV_W = 8
) (
   input  logic             CP,
   input  logic             CR,
   input  logic             en,
   input  logic [DIV_W-1:0] div,
   input  logic [1:0]       pattern_sel,
   input  logic [3:0]       seed,
   input  logic [3:0]       Q,
   output logic             S1,
   output logic             S0,
   output logic             Dsr,
   output logic             Dsl,
   output logic [3:0]       D,
   output logic             busy
);

   state_t     state_q, state_d;
   logic [1:0] pat_q, pat_d;
   logic [1:0] step_q, step_d;
   logic [1:0] mode_q, mode_d;
   logic       dsr_q, dsr_d;
   logic       dsl_q, dsl_d;
   logic [3:0] d_q, d_d;
   logic       running;
   logic       tick;
   logic       last_step;

   assign running   = (state_q == RUN_L) || (state_q == RUN_R);
   assign last_step = (step_q == 2'(BOUNCE_STEPS - 1));

   hc194_tick_div #(
      .DIV_W (DIV_W)
   ) u_tick_div (
      .clk_i  (CP),
      .rst_i  (CR),
      .clr_i  (!running),
      .en_i   (running),
      .div_i  (div),
      .tick_o (tick)
   );

   always_comb begin
      state_d = state_q;
      pat_d   = pat_q;
      step_d  = step_q;
      mode_d  = MODE_HOLD;
      dsr_d   = 1'b0;
      dsl_d   = 1'b0;
      d_d     = 4'b0000;
      // Dropping en overrides everything, including a tick in this cycle.
      if (!en) begin
         state_d = IDLE;
      end else begin
         case (state_q)
            IDLE: begin
               state_d = LOAD;
            end
            LOAD: begin
               mode_d  = MODE_LOAD;
               d_d     = seed;
               pat_d   = pattern_sel;
               step_d  = 2'd0;
               state_d = (pattern_sel == PAT_HOLD) ? HOLD_ST : RUN_L;
            end
            RUN_L: begin
               if (tick) begin
                  mode_d = MODE_SHL;
                  dsr_d  = shl_serial(pat_q, Q);
                  if (pat_q == PAT_BOUNCE) begin
                     if (last_step) begin
                        step_d  = 2'd0;
                        state_d = RUN_R;
                     end else begin
                        step_d = step_q + 2'd1;
                     end
                  end
               end
            end
            RUN_R: begin
               if (tick) begin
                  mode_d = MODE_SHR;
                  if (last_step) begin
                     step_d  = 2'd0;
                     state_d = RUN_L;
                  end else begin
                     step_d = step_q + 2'd1;
                  end
               end
            end
            HOLD_ST: begin
               state_d = HOLD_ST;
            end
            default: begin
               state_d = IDLE;
            end
         endcase
      end
   end

   always_ff @(posedge CP or posedge CR) begin
      if (CR) begin
         state_q <= IDLE;
         pat_q   <= PAT_RING;
         step_q  <= 2'd0;
         mode_q  <= MODE_HOLD;
         dsr_q   <= 1'b0;
         dsl_q   <= 1'b0;
         d_q     <= 4'b0000;
      end else begin
         state_q <= state_d;
         pat_q   <= pat_d;
         step_q  <= step_d;
         mode_q  <= mode_d;
         dsr_q   <= dsr_d;
         dsl_q   <= dsl_d;
         d_q     <= d_d;
      end
   end

   assign S1   = mode_q[1];
   assign S0   = mode_q[0];
   assign Dsr  = dsr_q;
   assign Dsl  = dsl_q;
   assign D    = d_q;
   assign busy = (state_q != IDLE);

endmodule
`default_nettype wire

// File: tb/tb_hc194_seq_ctrl.sv
`default_nettype none
// ============================================================================
// Module  : tb_hc194_seq_ctrl
// Brief   : Sequencer driving a behavioural 74HC194, scoreboarded per command.
// Revision: 1.0
// ============================================================================
module tb_hc194_seq_ctrl;

   logic       CP = 1'b0;
   logic       CR = 1'b1;
   logic       en = 1'b0;
   logic [7:0] div = 8'd1;
   logic [1:0] pattern_sel = 2'b00;
   logic [3:0] seed = 4'b0000;
   logic [3:0] Q;
   logic       S1, S0, Dsr, Dsl, busy;
   logic [3:0] D;

   typedef struct {
      logic [1:0] mode;
      logic [3:0] q;
      int         gap;
   } exp_t;

   exp_t exp_q[$];
   int   checks = 0;
   int   errors = 0;
   int   cyc = 0;
   int   last_cyc = 0;
   bit   mon_stop = 1'b0;
   logic [3:0] q_reg = 4'b0000;

   always #5 CP = ~CP;

   hc194_seq_ctrl #(.DIV_W(8)) dut (
      .CP          (CP),
      .CR          (CR),
      .en          (en),
      .div         (div),
      .pattern_sel (pattern_sel),
      .seed        (seed),
      .Q           (Q),
      .S1          (S1),
      .S0          (S0),
      .Dsr         (Dsr),
      .Dsl         (Dsl),
      .D           (D),
      .busy        (busy)
   );

   function automatic logic [3:0] apply194(input logic [3:0] q, input logic [1:0] s,
                                           input logic dsr, input logic dsl, input logic [3:0] d);
      case (s)
         2'b01:   return {q[2:0], dsr};
         2'b10:   return {dsl, q[3:1]};
         2'b11:   return d;
         default: return q;
      endcase
   endfunction

   // Downstream shift register; no own reset so it holds across CR.
   always @(posedge CP) q_reg <= apply194(q_reg, {S1, S0}, Dsr, Dsl, D);
   assign Q = q_reg;

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
      end
   endtask

   task automatic push(input logic [1:0] mode, input logic [3:0] q, input int gap);
      exp_t e;
      e.mode = mode;
      e.q    = q;
      e.gap  = gap;
      exp_q.push_back(e);
   endtask

   task automatic monitor();
      exp_t e;
      while (!mon_stop) begin
         @(negedge CP);
         cyc++;
         if ({S1, S0} != 2'b00) begin
            if (exp_q.size() == 0) begin
               check("unexpected_cmd", {S1, S0}, 2'b00);
            end else begin
               e = exp_q.pop_front();
               check("cmd_mode", {S1, S0}, e.mode);
               check("cmd_result_q", apply194(Q, {S1, S0}, Dsr, Dsl, D), e.q);
               if (e.gap != 0) check("cmd_gap", cyc - last_cyc, e.gap);
            end
            last_cyc = cyc;
         end
      end
   endtask

   // en rises just after a posedge; the following edge (k) enters LOAD.
   task automatic begin_run(input logic [3:0] s, input logic [1:0] p, input logic [7:0] dv);
      @(posedge CP);
      #1;
      check("idle_before_run", busy, 1'b0);
      seed        = s;
      pattern_sel = p;
      div         = dv;
      en          = 1'b1;
      push(2'b11, s, 0);
   endtask

   initial begin
      fork
         monitor();
      join_none

      // Reset state
      repeat (3) @(negedge CP);
      check("rst_S", {S1, S0}, 2'b00);
      check("rst_Dsr", Dsr, 1'b0);
      check("rst_Dsl", Dsl, 1'b0);
      check("rst_D", D, 4'b0000);
      check("rst_busy", busy, 1'b0);
      @(posedge CP);
      #1 CR = 1'b0;

      // Ring, div=1: period 2
      begin_run(4'b0001, 2'b00, 8'd1);
      push(2'b01, 4'b0010, 2);
      push(2'b01, 4'b0100, 2);
      push(2'b01, 4'b1000, 2);
      push(2'b01, 4'b0001, 2);
      repeat (10) @(posedge CP);
      #1 en = 1'b0;

      // Johnson, div=3: period 4; pattern_sel change mid-run must be ignored
      begin_run(4'b0000, 2'b01, 8'd3);
      push(2'b01, 4'b0001, 4);
      push(2'b01, 4'b0011, 4);
      push(2'b01, 4'b0111, 4);
      push(2'b01, 4'b1111, 4);
      push(2'b01, 4'b1110, 4);
      push(2'b01, 4'b1100, 4);
      push(2'b01, 4'b1000, 4);
      push(2'b01, 4'b0000, 4);
      repeat (5) @(posedge CP);
      #1 pattern_sel = 2'b11;
      repeat (29) @(posedge CP);
      #1 en = 1'b0;

      // Bounce, div=0 acts as 1; en drops in the tick cycle of the 9th step
      begin_run(4'b0001, 2'b10, 8'd0);
      push(2'b01, 4'b0010, 2);
      push(2'b01, 4'b0100, 2);
      push(2'b01, 4'b1000, 2);
      push(2'b10, 4'b0100, 2);
      push(2'b10, 4'b0010, 2);
      push(2'b10, 4'b0001, 2);
      push(2'b01, 4'b0010, 2);
      push(2'b01, 4'b0100, 2);
      repeat (19) @(posedge CP);
      #1 en = 1'b0;
      @(posedge CP);
      #1;
      check("disable_busy", busy, 1'b0);
      check("disable_S", {S1, S0}, 2'b00);
      repeat (4) @(negedge CP);
      check("disable_Q_frozen", Q, 4'b0100);

      // Load-and-hold, then restart as ring
      begin_run(4'b1010, 2'b11, 8'd1);
      repeat (8) @(posedge CP);
      #1;
      check("hold_Q", Q, 4'b1010);
      check("hold_busy", busy, 1'b1);
      check("hold_S", {S1, S0}, 2'b00);
      en = 1'b0;
      @(posedge CP);
      #1;
      check("hold_exit_busy", busy, 1'b0);
      begin_run(4'b0110, 2'b00, 8'd1);
      push(2'b01, 4'b1100, 2);
      push(2'b01, 4'b1001, 2);
      push(2'b01, 4'b0011, 2);
      repeat (8) @(posedge CP);
      #1 en = 1'b0;

      // Reset while the first shift command is on the outputs
      begin_run(4'b0001, 2'b00, 8'd1);
      repeat (4) @(posedge CP);
      #1;
      check("pre_reset_cmd", {S1, S0}, 2'b01);
      #1 CR = 1'b1;
      #1;
      check("arst_S", {S1, S0}, 2'b00);
      check("arst_Dsr", Dsr, 1'b0);
      check("arst_Dsl", Dsl, 1'b0);
      check("arst_D", D, 4'b0000);
      check("arst_busy", busy, 1'b0);
      repeat (3) @(negedge CP);
      check("arst_Q_held", Q, 4'b0001);
      seed = 4'b1001;
      @(posedge CP);
      #1 CR = 1'b0;
      push(2'b11, 4'b1001, 0);
      push(2'b01, 4'b0011, 2);
      @(posedge CP);
      #1;
      check("reload_busy", busy, 1'b1);
      repeat (3) @(posedge CP);
      #1 en = 1'b0;

      repeat (5) @(negedge CP);
      check("scoreboard_drain", exp_q.size(), 0);
      check("final_Q", Q, 4'b0011);
      mon_stop = 1'b1;
      repeat (2) @(negedge CP);
      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
`default_nettype wire
